// File: rtl/display_owner_arbiter_if.sv
// Pixel-path bundle between the renderers and display_owner_arbiter.
// With DISP_ARB_LOCK_EN defined, the bundle also carries the lock input.
interface display_owner_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [10:0]           h_coord;
  logic [9:0]            v_coord;
  logic [NUM_REQ-1:0]    req;
  logic [12*NUM_REQ-1:0] req_rgb;
`ifdef DISP_ARB_LOCK_EN
  logic                  lock;
`endif
  logic [11:0]           rgb_o;
  logic [NUM_REQ-1:0]    grant;
  logic [1:0]            owner_idx;
  logic                  switch_pulse;

  // No valid/ready pair here: req is a level held by each renderer, and the
  // arbiter answers only at frame boundaries through grant/switch_pulse.
`ifdef DISP_ARB_LOCK_EN
  modport master (
    output h_coord, v_coord, req, req_rgb, lock,
    input  rgb_o, grant, owner_idx, switch_pulse
  );
  modport slave (
    input  h_coord, v_coord, req, req_rgb, lock,
    output rgb_o, grant, owner_idx, switch_pulse
  );
`else
  modport master (
    output h_coord, v_coord, req, req_rgb,
    input  rgb_o, grant, owner_idx, switch_pulse
  );
  modport slave (
    input  h_coord, v_coord, req, req_rgb,
    output rgb_o, grant, owner_idx, switch_pulse
  );
`endif
endinterface

// File: rtl/display_owner_arbiter.sv
// Frame-synchronous round-robin owner of the VGA pixel path, with minimum hold and blank frames.
// Optional macro DISP_ARB_LOCK_EN adds a lock input that freezes the current ownership.
module display_owner_arbiter #(
  parameter int          NUM_REQ         = 2,
  parameter int          V_ACTIVE        = 600,
  parameter int          MIN_HOLD_FRAMES = 30,
  parameter int          BLANK_FRAMES    = 2,
  parameter logic [11:0] IDLE_COLOR      = 12'h000
) (
  input  logic                   clk,
  input  logic                   arst,
  display_owner_arbiter_if.slave bus,
  output logic [1:0]             state
);
  localparam int HOLD_W  = (MIN_HOLD_FRAMES < 1) ? 1 : $clog2(MIN_HOLD_FRAMES + 1);
  localparam int BLANK_W = (BLANK_FRAMES < 1) ? 1 : $clog2(BLANK_FRAMES + 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(MIN_HOLD_FRAMES);
  localparam logic [BLANK_W-1:0] BLANK_END = BLANK_W'(BLANK_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN   = 2'd1,
    S_BLANK = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           owner_q, owner_d;
  logic [1:0]           rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]    hold_q, hold_d, hold_inc;
  logic [BLANK_W-1:0]   blank_q, blank_d, blank_inc;
  logic                 pulse_q, pulse_d;
  logic                 tick_q, boundary;
  logic [11:0]          rgb_q, rgb_d, own_rgb;
  logic [NUM_REQ-1:0]   owner_oh;
  logic                 owner_req, hold_done, lock_own;
  logic [2:0]           pick_all, pick_oth;
  logic                 grant_en;
  logic [1:0]           grant_idx;

  // Returns {found, index}: the set bit with the smallest distance upward from ptr.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] mask, input logic [1:0] ptr);
    logic [2:0] res;
    int         best;
    int         off;
    res  = 3'b000;
    best = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      off = j - int'(ptr);
      if (off < 0) off = off + NUM_REQ;
      if (mask[j] && (off < best)) begin
        best = off;
        res  = {1'b1, 2'(j)};
      end
    end
    return res;
  endfunction

  function automatic logic [1:0] ptr_after(input logic [1:0] idx);
    return (int'(idx) + 1 >= NUM_REQ) ? 2'd0 : idx + 2'd1;
  endfunction

  assign boundary = (bus.v_coord == 10'(V_ACTIVE)) && (bus.h_coord == 11'd0);

`ifdef DISP_ARB_LOCK_EN
  assign lock_own = bus.lock;
`else
  assign lock_own = 1'b0;
`endif

  always_comb begin
    owner_oh = '0;
    own_rgb  = 12'h000;
    for (int j = 0; j < NUM_REQ; j++) begin
      owner_oh[j] = (owner_q == 2'(j));
      if (owner_q == 2'(j)) own_rgb = bus.req_rgb[12*j +: 12];
    end
  end

  // owner_q names the pending owner while in BLANK, so owner_req there means "next still wants it".
  assign owner_req = |(bus.req & owner_oh);
  assign pick_all  = rr_pick(bus.req, rr_ptr_q);
  assign pick_oth  = rr_pick(bus.req & ~owner_oh, rr_ptr_q);
  assign hold_inc  = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
  // Compared after this tick's increment: the owner has then completed hold_inc frames.
  assign hold_done = (hold_inc >= HOLD_MAX);
  assign blank_inc = blank_q + BLANK_W'(1);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    hold_d    = hold_q;
    blank_d   = blank_q;
    pulse_d   = 1'b0;
    grant_en  = 1'b0;
    grant_idx = owner_q;
    if (tick_q) begin
      case (state_q)
        S_IDLE: begin
          if (pick_all[2]) begin
            grant_en  = 1'b1;
            grant_idx = pick_all[1:0];
          end
        end
        S_OWN: begin
          hold_d = hold_inc;
          if (!lock_own) begin
            if (!owner_req && !pick_oth[2]) begin
              state_d = S_IDLE;
            end else if (pick_oth[2] && (!owner_req || hold_done)) begin
              if (BLANK_FRAMES == 0) begin
                grant_en  = 1'b1;
                grant_idx = pick_oth[1:0];
              end else begin
                state_d = S_BLANK;
                owner_d = pick_oth[1:0];
                blank_d = '0;
              end
            end
          end
        end
        S_BLANK: begin
          blank_d = blank_inc;
          if (blank_inc == BLANK_END) begin
            if (owner_req) begin
              grant_en  = 1'b1;
              grant_idx = owner_q;
            end else if (pick_all[2]) begin
              grant_en  = 1'b1;
              grant_idx = pick_all[1:0];
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (grant_en) begin
      state_d  = S_OWN;
      owner_d  = grant_idx;
      rr_ptr_d = ptr_after(grant_idx);
      hold_d   = '0;
      pulse_d  = 1'b1;
    end
  end

  always_comb begin
    case (state_q)
      S_OWN:   rgb_d = own_rgb;
      S_BLANK: rgb_d = 12'h000;
      default: rgb_d = IDLE_COLOR;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= S_IDLE;
      owner_q  <= 2'd0;
      rr_ptr_q <= 2'd0;
      hold_q   <= '0;
      blank_q  <= '0;
      pulse_q  <= 1'b0;
      tick_q   <= 1'b0;
      rgb_q    <= 12'h000;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
      blank_q  <= blank_d;
      pulse_q  <= pulse_d;
      tick_q   <= boundary;
      rgb_q    <= rgb_d;
    end
  end

  assign bus.rgb_o        = rgb_q;
  assign bus.grant        = (state_q == S_OWN) ? owner_oh : '0;
  assign bus.owner_idx    = owner_q;
  assign bus.switch_pulse = pulse_q;
  assign state            = state_q;
endmodule
